// File: rtl/seg7_pkg.sv
// Shared 7-segment types and the hex-to-segment encoding used by the display scanner.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic seg7_t hex_to_seg(input logic [3:0] nib);
    seg7_t seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h18;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational nibble-to-segment decoder shared by the scanner's selected digit.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed 7-segment scanner with frame-synchronous loading, leading-zero
// blanking, per-digit decimal points and per-digit blink.
module hex_display_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024,
  parameter int BLINK_DIV  = 2**22
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_sync,
  output logic                    pending
);

  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [VAL_W-1:0]      shadow_value, active_value;
  logic [NUM_DIGITS-1:0] shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0] shadow_blink, active_blink;
  logic                  shadow_blz, active_blz;

  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      idx;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;

  logic                  scan_wrap, blink_wrap, commit;
  logic [SCAN_W-1:0]     scan_cnt_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [BLINK_W-1:0]    blink_cnt_nxt;
  logic                  blink_phase_nxt;

  logic [VAL_W-1:0]      act_value_nxt;
  logic [NUM_DIGITS-1:0] act_dp_nxt, act_blink_nxt;
  logic                  act_blz_nxt;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;
  logic [3:0]            nib_sel;
  logic                  dp_sel, lz_sel, blink_sel;
  logic [NUM_DIGITS-1:0] an_sel;
  seg7_t                 seg_lut;

  // Next-state of counters and active regs; outputs decode from these so the
  // committed value appears on digit 0 together with frame_sync.
  always_comb begin
    scan_wrap       = (scan_cnt == SCAN_LAST);
    blink_wrap      = (blink_cnt == BLINK_LAST);
    commit          = scan_wrap && (idx == LAST_IDX);
    scan_cnt_nxt    = scan_wrap ? '0 : scan_cnt + 1'b1;
    blink_cnt_nxt   = blink_wrap ? '0 : blink_cnt + 1'b1;
    blink_phase_nxt = blink_wrap ? ~blink_phase : blink_phase;

    idx_nxt = idx;
    if (scan_wrap)
      idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    act_value_nxt = active_value;
    act_dp_nxt    = active_dp;
    act_blink_nxt = active_blink;
    act_blz_nxt   = active_blz;
    if (commit && pending) begin
      act_value_nxt = shadow_value;
      act_dp_nxt    = shadow_dp;
      act_blink_nxt = shadow_blink;
      act_blz_nxt   = shadow_blz;
    end

    // A digit is a leading zero when it and every digit above it are zero.
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (act_value_nxt[4*k +: 4] == 4'h0);
      lz_blank[k] = act_blz_nxt && zero_run && (k != 0);
    end

    nib_sel   = act_value_nxt[4*idx_nxt +: 4];
    dp_sel    = act_dp_nxt[idx_nxt];
    lz_sel    = lz_blank[idx_nxt];
    blink_sel = act_blink_nxt[idx_nxt] && blink_phase_nxt;

    an_sel          = '0;
    an_sel[idx_nxt] = 1'b1;
  end

  seg7_lut u_lut (
    .nib (nib_sel),
    .seg (seg_lut)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blink <= '0;
      shadow_blz   <= 1'b0;
      active_value <= '0;
      active_dp    <= '0;
      active_blink <= '0;
      active_blz   <= 1'b0;
      scan_cnt     <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      pending      <= 1'b0;
      frame_sync   <= 1'b0;
      seg_n        <= SEG_BLANK;
      dp_n         <= 1'b1;
      an_n         <= '1;
    end else begin
      scan_cnt    <= scan_cnt_nxt;
      idx         <= idx_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;

      active_value <= act_value_nxt;
      active_dp    <= act_dp_nxt;
      active_blink <= act_blink_nxt;
      active_blz   <= act_blz_nxt;

      // A load on the commit edge lands in shadow after the old shadow moved
      // to active, so it stays pending for the next frame.
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
        shadow_blink <= blink_en;
        shadow_blz   <= blank_lz;
        pending      <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end

      frame_sync <= commit;
      seg_n      <= (lz_sel || blink_sel) ? SEG_BLANK : seg_lut;
      dp_n       <= ~(dp_sel && !lz_sel && !blink_sel);
      an_n       <= ~an_sel;
    end
  end

endmodule
